// File: rtl/crc_recv_if.sv
// Word-stream bundle between a CRC-32 frame source and the crc_recv checker.
// CRC_RECV_STATS_EN adds the frame/error statistics counters to the bundle.
interface crc_recv_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_in_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  frame_done;
  logic                  crc_ok;
  logic                  crc_err;
`ifdef CRC_RECV_STATS_EN
  logic [15:0]           frame_count;
  logic [15:0]           err_count;

  modport slave (
    input  data_in, data_in_valid,
    output data_out, data_out_valid, frame_done, crc_ok, crc_err,
    output frame_count, err_count
  );

  modport master (
    output data_in, data_in_valid,
    input  data_out, data_out_valid, frame_done, crc_ok, crc_err,
    input  frame_count, err_count
  );
`else
  modport slave (
    input  data_in, data_in_valid,
    output data_out, data_out_valid, frame_done, crc_ok, crc_err
  );

  modport master (
    output data_in, data_in_valid,
    input  data_out, data_out_valid, frame_done, crc_ok, crc_err
  );
`endif
endinterface

// File: rtl/crc_recv.sv
// CRC-32/MPEG-2 frame checker: forwards FRAME_WORDS payload words, strips the CRC word
// and pulses pass/fail per frame. CRC_RECV_STATS_EN adds saturating frame/error counters.
//
// state   | meaning
// RX_DATA | accepting payload words 0..FRAME_WORDS-1, forwarding each one
// RX_CRC  | next valid word is the CRC word; evaluate residue and rearm
module crc_recv #(
  parameter int DATA_WIDTH  = 32,
  parameter int FRAME_WORDS = 4
) (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  crc_recv_if.slave   bus
);

  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [15:0] LAST_IDX = 16'(FRAME_WORDS - 1);

  typedef enum logic {
    RX_DATA = 1'b0,
    RX_CRC  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [31:0]           crc_q, crc_d;
  logic [31:0]           crc_upd;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dvalid_q, dvalid_d;
  logic                  done_q, done_d;
  logic                  ok_q, ok_d;
  logic                  err_q, err_d;

  // Whole word folded in at once, MSB first: XOR the word into the register, then 32 shifts.
  function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    c = crc ^ data;
    for (int i = 0; i < 32; i++) begin
      c = c[31] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

  always_ff @(posedge axis_aclk or posedge axis_aresetn) begin
    if (axis_aresetn) begin
      state_q  <= RX_DATA;
      cnt_q    <= '0;
      crc_q    <= CRC_INIT;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      crc_q    <= crc_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      done_q   <= done_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    done_d   = 1'b0;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    crc_upd  = crc32_word(crc_q, bus.data_in);

    if (bus.data_in_valid) begin
      unique case (state_q)
        RX_DATA: begin
          dout_d   = bus.data_in;
          dvalid_d = 1'b1;
          crc_d    = crc_upd;
          if (cnt_q == LAST_IDX) begin
            state_d = RX_CRC;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        RX_CRC: begin
          // Running the CRC over its own value leaves a zero residue on a good frame.
          done_d  = 1'b1;
          ok_d    = (crc_upd == 32'h0);
          err_d   = (crc_upd != 32'h0);
          crc_d   = CRC_INIT;
          cnt_d   = '0;
          state_d = RX_DATA;
        end
        default: state_d = RX_DATA;
      endcase
    end
  end

  assign bus.data_out       = dout_q;
  assign bus.data_out_valid = dvalid_q;
  assign bus.frame_done     = done_q;
  assign bus.crc_ok         = ok_q;
  assign bus.crc_err        = err_q;

`ifdef CRC_RECV_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] err_cnt_q;

  always_ff @(posedge axis_aclk or posedge axis_aresetn) begin
    if (axis_aresetn) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (done_q && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (err_q && (err_cnt_q != 16'hFFFF))    err_cnt_q   <= err_cnt_q + 16'd1;
    end
  end

  assign bus.frame_count = frame_cnt_q;
  assign bus.err_count   = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc_recv.sv
// Directed bench for crc_recv: a 4-word-frame instance checked cycle by cycle and a
// 1-word-frame instance for the alternating corner; stats checks under CRC_RECV_STATS_EN.
module tb_crc_recv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  crc_recv_if #(.DATA_WIDTH(32)) bus4 ();
  crc_recv_if #(.DATA_WIDTH(32)) bus1 ();

  crc_recv #(.DATA_WIDTH(32), .FRAME_WORDS(4)) dut (
    .axis_aclk(clk), .axis_aresetn(rst), .bus(bus4)
  );
  crc_recv #(.DATA_WIDTH(32), .FRAME_WORDS(1)) dut1 (
    .axis_aclk(clk), .axis_aresetn(rst), .bus(bus1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference CRC-32/MPEG-2, bit-serial over each word MSB first.
  function automatic logic [31:0] crc_ref(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] c;
    logic [31:0] w [4];
    logic        fb;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      for (int b = 31; b >= 0; b--) begin
        fb = c[31] ^ w[k][b];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C1_1DB7;
      end
    end
    return c;
  endfunction

  // Expectations for the 4-word instance at the coming rising edge.
  logic        mon_en   = 1'b0;
  logic        exp_dv   = 1'b0;
  logic [31:0] exp_data = '0;
  logic        exp_done = 1'b0;
  logic        exp_ok   = 1'b0;
  int          dv_cnt   = 0;
  int          done_cnt = 0;
  int          ok_cnt   = 0;

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      check_eq("dout_valid", 32'(bus4.data_out_valid), 32'(exp_dv));
      if (exp_dv) check_eq("dout", bus4.data_out, exp_data);
      check_eq("frame_done", 32'(bus4.frame_done), 32'(exp_done));
      check_eq("crc_ok", 32'(bus4.crc_ok), 32'(exp_done & exp_ok));
      check_eq("crc_err", 32'(bus4.crc_err), 32'(exp_done & ~exp_ok));
      if (bus4.data_out_valid) dv_cnt++;
      if (bus4.frame_done) done_cnt++;
      if (bus4.crc_ok) ok_cnt++;
    end
  end

  task automatic cyc(input logic v, input logic [31:0] d, input logic dv,
                     input logic done, input logic ok);
    @(negedge clk);
    bus4.data_in       = d;
    bus4.data_in_valid = v;
    exp_dv   = dv;
    exp_data = d;
    exp_done = done;
    exp_ok   = ok;
  endtask

  task automatic pay(input logic [31:0] d);
    cyc(1'b1, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic crcw(input logic [31:0] d, input logic ok);
    cyc(1'b1, d, 1'b0, 1'b1, ok);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clr_counts();
    dv_cnt   = 0;
    done_cnt = 0;
    ok_cnt   = 0;
  endtask

  logic [31:0] c1, c2;
  time         t_done [3];

  initial begin
    bus4.data_in = '0; bus4.data_in_valid = 1'b0;
    bus1.data_in = '0; bus1.data_in_valid = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_dout", bus4.data_out, 32'h0);
    check_eq("rst_dv", 32'(bus4.data_out_valid), 32'h0);
    check_eq("rst_done", 32'(bus4.frame_done), 32'h0);
    check_eq("rst_ok", 32'(bus4.crc_ok), 32'h0);
    check_eq("rst_err", 32'(bus4.crc_err), 32'h0);
    check_eq("rst1_dv", 32'(bus1.data_out_valid), 32'h0);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Corrupted CRC first so the stats counters start from a known point.
    clr_counts();
    pay(32'hFFFF_FFFF); pay(32'h0); pay(32'h0); pay(32'h0);
    crcw(32'h0000_0001, 1'b0);
    idle(2);
`ifdef CRC_RECV_STATS_EN
    check_eq("stat_err_1", 32'(bus4.err_count), 32'h1);
    check_eq("stat_frame_1", 32'(bus4.frame_count), 32'h1);
`endif

    // Golden frame
    clr_counts();
    pay(32'hFFFF_FFFF); pay(32'h0); pay(32'h0); pay(32'h0);
    crcw(32'h0000_0000, 1'b1);
    idle(1);
    check_eq("golden_ok_cnt", 32'(ok_cnt), 32'd1);
    check_eq("golden_dv_cnt", 32'(dv_cnt), 32'd4);

    // Back-to-back frames with a gap inside frame 2
    c1 = crc_ref(32'd5, 32'd3, 32'd678, 32'd76);
    c2 = crc_ref(32'd89, 32'd0, 32'd0, 32'd0);
    clr_counts();
    pay(32'd5); pay(32'd3); pay(32'd678); pay(32'd76);
    crcw(c1, 1'b1);
    pay(32'd89); pay(32'd0);
    idle(2);
    pay(32'd0); pay(32'd0);
    crcw(c2, 1'b1);
    idle(2);
    check_eq("b2b_ok_cnt", 32'(ok_cnt), 32'd2);
    check_eq("b2b_done_cnt", 32'(done_cnt), 32'd2);
    check_eq("b2b_dv_cnt", 32'(dv_cnt), 32'd8);

    // Mid-frame reset: partial frame is discarded without status
    clr_counts();
    pay(32'hA5A5_0001); pay(32'hA5A5_0002);
    @(negedge clk);
    rst = 1'b1;
    bus4.data_in_valid = 1'b0;
    exp_dv = 1'b0; exp_done = 1'b0; exp_ok = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_dout", bus4.data_out, 32'h0);
    check_eq("midrst_dv", 32'(bus4.data_out_valid), 32'h0);
`ifdef CRC_RECV_STATS_EN
    check_eq("midrst_stat", 32'(bus4.frame_count), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    pay(32'hFFFF_FFFF); pay(32'h0); pay(32'h0); pay(32'h0);
    crcw(32'h0000_0000, 1'b1);
    idle(2);
    check_eq("midrst_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("midrst_ok_cnt", 32'(ok_cnt), 32'd1);

    // FRAME_WORDS=1: payload/CRC alternate, three passing frames back-to-back
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus1.data_in = 32'hFFFF_FFFF; bus1.data_in_valid = 1'b1;
      @(posedge clk);
      #1;
      check_eq("fw1_dv", 32'(bus1.data_out_valid), 32'h1);
      check_eq("fw1_dout", bus1.data_out, 32'hFFFF_FFFF);
      check_eq("fw1_nodone", 32'(bus1.frame_done), 32'h0);
      @(negedge clk);
      bus1.data_in = 32'h0;
      @(posedge clk);
      #1;
      check_eq("fw1_done", 32'(bus1.frame_done), 32'h1);
      check_eq("fw1_ok", 32'(bus1.crc_ok), 32'h1);
      check_eq("fw1_crc_dv", 32'(bus1.data_out_valid), 32'h0);
      t_done[k] = $time;
    end
    @(negedge clk);
    bus1.data_in_valid = 1'b0;
    check_eq("fw1_gap01", 32'(t_done[1] - t_done[0]), 32'd20);
    check_eq("fw1_gap12", 32'(t_done[2] - t_done[1]), 32'd20);

`ifdef CRC_RECV_STATS_EN
    // Saturation on the 1-word instance (3 good frames already counted).
    bus1.data_in_valid = 1'b1;
    for (int k = 0; k < 65537; k++) begin
      bus1.data_in = 32'hFFFF_FFFF;
      @(negedge clk);
      bus1.data_in = 32'h0000_0001;
      @(negedge clk);
    end
    bus1.data_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("sat_err", 32'(bus1.err_count), 32'hFFFF);
    check_eq("sat_frame", 32'(bus1.frame_count), 32'hFFFF);
    bus1.data_in_valid = 1'b1;
    bus1.data_in = 32'hFFFF_FFFF;
    @(negedge clk);
    bus1.data_in = 32'h0000_0001;
    @(negedge clk);
    bus1.data_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("sat_err_hold", 32'(bus1.err_count), 32'hFFFF);
    check_eq("sat_frame_hold", 32'(bus1.frame_count), 32'hFFFF);
`endif

    idle(2);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/crc_recv.md
# crc_recv

CRC-32 frame receiver/checker: the receive-side counterpart of `crc_trans` on the same word stream. It accepts fixed-length frames of `FRAME_WORDS` payload words followed by one CRC word. Payload is forwarded with one cycle of latency and the CRC word is stripped. A one-cycle pass/fail status is reported per frame.

## Interface
- `DATA_WIDTH`, 32: word width; only 32 is supported (CRC-32 datapath).
- `FRAME_WORDS`, 4: payload words per frame, range 1..65535; the CRC word is extra.
- `axis_aclk` in 1: sole clock, rising edge.
- `axis_aresetn` in 1: asynchronous, active-high reset. Despite the name, 1 = reset.
- `data_in` in `DATA_WIDTH`: incoming word, sampled when `data_in_valid`=1.
- `data_in_valid` in 1: word-present qualifier. No backpressure; every valid word is consumed.
- `data_out` out `DATA_WIDTH`: forwarded payload word.
- `data_out_valid` out 1: `data_out` holds a payload word.
- `frame_done` out 1: one-cycle pulse after a frame's CRC word is consumed.
- `crc_ok` out 1: CRC matched; meaningful only with `frame_done`.
- `crc_err` out 1: CRC mismatch; meaningful only with `frame_done`.

## Operation
- The CRC is CRC-32/MPEG-2:
  - polynomial 0x04C11DB7, init 0xFFFFFFFF, no reflection, no final XOR;
  - each 32-bit word is processed MSB first, one word per cycle, using a combinational parallel update.
- Residue check: the CRC is run over all `FRAME_WORDS`+1 words, including the CRC word. The frame passes if and only if the final register is 0x00000000.
- State machine:
  - `RX_DATA`: the word counter counts accepted payload words 0..`FRAME_WORDS`-1. When the last payload word is accepted, go to `RX_CRC`.
  - `RX_CRC`: the next valid word is the CRC word. Evaluate the residue, load the CRC register with 0xFFFFFFFF, clear the counter, and return to `RX_DATA`.
- Cycles with `data_in_valid`=0 hold state, counter and CRC register unchanged. Gaps may occur anywhere in a frame.
- Back-to-back frames are supported. A valid word in the cycle immediately after the CRC word is payload word 0 of the next frame and uses init 0xFFFFFFFF.
- There is no frame-start marker. Alignment is established only by reset and kept by counting.
- Reset mid-frame aborts the frame: no status is emitted, and after release the next valid word is payload word 0.

## Timing
- Reset values:
  - `data_out`=0, `data_out_valid`=0, `frame_done`=0, `crc_ok`=0, `crc_err`=0;
  - state `RX_DATA`, counter 0, CRC register 0xFFFFFFFF.
- Payload latency is 1 cycle. `data_out`/`data_out_valid` are registered copies of an accepted payload word. `data_out_valid` is 0 in all other cycles. `data_out` holds its last value when not valid.
- The CRC word never appears on `data_out`. `data_out_valid`=0 in the cycle after the CRC word.
- `frame_done` rises 1 cycle after the CRC word is sampled and lasts exactly 1 cycle.
  - In that same cycle, exactly one of `crc_ok`/`crc_err` is 1.
  - Both are 0 whenever `frame_done`=0.
- With `FRAME_WORDS`=1, the state alternates `RX_DATA`/`RX_CRC` on every valid word.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `CRC_RECV_STATS_EN` defined: adds two output ports, both reset to 0 and saturating at 0xFFFF:
  - `frame_count` (16 bits): increments on every `frame_done`;
  - `err_count` (16 bits): increments on every `crc_err`.
- `CRC_RECV_STATS_EN` undefined: neither port nor its counters exist; all other behaviour is identical.

## Test plan
- Golden frame (`FRAME_WORDS`=4):
  - Stimulus: words 0xFFFFFFFF, 0, 0, 0 with CRC 0x00000000, all continuous valid.
  - Required: `data_out` shows the 4 payload words on the 4 cycles after their input; `frame_done`=1 and `crc_ok`=1 one cycle after the CRC word.
- Corrupted CRC:
  - Stimulus: the same frame with CRC word 0x00000001.
  - Required: `frame_done`=1, `crc_err`=1, `crc_ok`=0. With stats enabled, `err_count`=1 and `frame_count`=1.
- Back-to-back frames with gaps:
  - Stimulus: frame 1 with payload 5, 3, 678, 76 and CRC from a software model, then frame 2 with payload 89, 0, 0, 0 and CRC from the model. Frame 2 starts the cycle after frame 1's CRC word. Insert 2 idle cycles between words 1 and 2 of frame 2.
  - Required: two `crc_ok` pulses; exactly 8 `data_out_valid` cycles; the CRC words are never output.
- Mid-frame reset:
  - Stimulus: 2 payload words, then `axis_aresetn`=1 for 1 cycle, then the golden frame.
  - Required: all outputs are 0 during reset; exactly one `frame_done`, with `crc_ok`=1.
- `FRAME_WORDS`=1 corner:
  - Stimulus: payload 0xFFFFFFFF, then CRC 0x00000000, repeated 3 times back-to-back.
  - Required: three `crc_ok` pulses, two cycles apart.
- Stats saturation (`CRC_RECV_STATS_EN`):
  - Stimulus: 65537 bad frames, with `FRAME_WORDS` overridden to 1 for bench speed.
  - Required: `err_count`=0xFFFF and `frame_count`=0xFFFF, holding.
